// File: rtl/comparador_pkg.sv
// rtl/comparador_pkg.sv - relation codes and FSM states for the serial comparators
package comparador_pkg;

  localparam logic [1:0] REL_NADA  = 2'b00;
  localparam logic [1:0] REL_IGUAL = 2'b01;
  localparam logic [1:0] REL_MAYOR = 2'b10;
  localparam logic [1:0] REL_MENOR = 2'b11;

  typedef enum logic [1:0] {
    REPOSO     = 2'b00,
    COMPARANDO = 2'b01,
    LISTO      = 2'b10
  } estado_t;

endpackage

// File: rtl/celda_tipica_der_izq.sv
// rtl/celda_tipica_der_izq.sv - right-to-left comparator cell: a differing bit overrides the incoming relation
module celda_tipica_der_izq
  import comparador_pkg::*;
(
  input  logic p,
  input  logic q,
  input  logic Ai,
  input  logic Bi,
  output logic P,
  output logic Q
);

  always_comb begin
    {P, Q} = {p, q};
    if (Ai != Bi) begin
      {P, Q} = Ai ? REL_MAYOR : REL_MENOR;
    end
  end

endmodule

// File: rtl/comparador_serial_der_izq.sv
// rtl/comparador_serial_der_izq.sv - LSB-first serial magnitude comparator with registered outputs
module comparador_serial_der_izq
  import comparador_pkg::*;
#(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  input  logic       bit_valido,
  input  logic       ai,
  input  logic       bi,
  output logic       ocupado,
  output logic       listo,
  output logic [1:0] relacion
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rel_q, rel_d;
  logic          ocupado_q, ocupado_d;
  logic          listo_q, listo_d;
  logic [1:0]    relacion_q, relacion_d;
  logic [1:0]    rel_celda;

  celda_tipica_der_izq u_celda (
    .p  (rel_q[1]),
    .q  (rel_q[0]),
    .Ai (ai),
    .Bi (bi),
    .P  (rel_celda[1]),
    .Q  (rel_celda[0])
  );

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    rel_d      = rel_q;
    relacion_d = relacion_q;

    // inicio wins in every state, so it also serves as abort and as back-to-back start
    if (inicio) begin
      estado_d   = COMPARANDO;
      cnt_d      = '0;
      rel_d      = REL_IGUAL;
      relacion_d = REL_NADA;
    end else begin
      case (estado_q)
        COMPARANDO: begin
          if (bit_valido) begin
            rel_d = rel_celda;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == ULTIMO) begin
              estado_d   = LISTO;
              cnt_d      = '0;
              relacion_d = rel_celda;
            end
          end
        end
        LISTO:   estado_d = REPOSO;
        default: estado_d = REPOSO;
      endcase
    end

    ocupado_d = (estado_d == COMPARANDO);
    listo_d   = (estado_d == LISTO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= REPOSO;
      cnt_q      <= '0;
      rel_q      <= REL_IGUAL;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
      relacion_q <= REL_NADA;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      rel_q      <= rel_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
      relacion_q <= relacion_d;
    end
  end

  assign ocupado  = ocupado_q;
  assign listo    = listo_q;
  assign relacion = relacion_q;

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// tb/tb_comparador_serial_der_izq.sv - directed bench with result scoreboard for comparador_serial_der_izq
module tb_comparador_serial_der_izq;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inicio;
  logic       bit_valido;
  logic       ai;
  logic       bi;
  logic       ocupado;
  logic       listo;
  logic [1:0] relacion;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [1:0] esperados[$];

  comparador_serial_der_izq #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inicio     (inicio),
    .bit_valido (bit_valido),
    .ai         (ai),
    .bi         (bi),
    .ocupado    (ocupado),
    .listo      (listo),
    .relacion   (relacion)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference relation for LSB-first words: the most significant differing bit decides
  function automatic logic [1:0] modelo(input logic [7:0] a, input logic [7:0] b);
    if (a > b) return 2'b10;
    if (a < b) return 2'b11;
    return 2'b01;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (listo === 1'b1) begin
        check("listo_excl_ocupado", {7'd0, ocupado}, 8'd0);
        if (esperados.size() == 0) begin
          check("listo_inesperado", {7'd0, listo}, 8'd0);
        end else begin
          check("relacion_final", {6'd0, relacion}, {6'd0, esperados.pop_front()});
        end
      end else if (ocupado === 1'b1) begin
        check("relacion_nada_ocupado", {6'd0, relacion}, 8'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    check("ocupado_tras_inicio", {7'd0, ocupado}, 8'd1);
  endtask

  task automatic bits(input logic [7:0] a, input logic [7:0] b, input int n,
                      input bit gap, input bit espera);
    if (espera) esperados.push_back(modelo(a, b));
    for (int i = 0; i < n; i++) begin
      bit_valido = 1'b1;
      ai = a[i];
      bi = b[i];
      step();
      if (gap && i != n - 1) begin
        bit_valido = 1'b0;
        ai = 1'($urandom);
        bi = 1'($urandom);
        step();
      end
    end
    bit_valido = 1'b0;
    if (espera) check("listo_latencia", {7'd0, listo}, 8'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 5 && esperados.size() != 0; k++) step();
    check("scoreboard_vacio", 8'(esperados.size()), 8'd0);
  endtask

  task automatic word(input logic [7:0] a, input logic [7:0] b, input bit gap);
    start();
    bits(a, b, N, gap, 1'b1);
    drain();
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    inicio = 1'b0;
    bit_valido = 1'b0;
    ai = 1'b0;
    bi = 1'b0;
    step();
    step();
    check("reset_ocupado", {7'd0, ocupado}, 8'd0);
    check("reset_listo", {7'd0, listo}, 8'd0);
    check("reset_relacion", {6'd0, relacion}, 8'd0);
    rst_n = 1'b1;
    step();

    // bit_valido in REPOSO must be ignored
    bit_valido = 1'b1;
    step();
    step();
    bit_valido = 1'b0;
    check("reposo_ignora_bits", {7'd0, ocupado}, 8'd0);

    word(8'hA5, 8'hA5, 1'b0);
    step();
    step();
    check("relacion_mantiene", {6'd0, relacion}, 8'h01);
    check("reposo_listo_bajo", {7'd0, listo}, 8'd0);

    word(8'h80, 8'h7F, 1'b0);
    word(8'h7F, 8'h80, 1'b0);
    word(8'h01, 8'h02, 1'b1);

    // Abort after 4 bits: only the restarted word may report
    start();
    bits(8'hFF, 8'h00, 4, 1'b0, 1'b0);
    start();
    bits(8'h10, 8'h10, N, 1'b0, 1'b1);
    drain();
    step();

    // Back-to-back: inicio during the LISTO cycle
    start();
    bits(8'h3C, 8'h3D, N, 1'b0, 1'b1);
    start();
    bits(8'hFF, 8'hFE, N, 1'b0, 1'b1);
    drain();
    step();

    // Asynchronous reset after 5 bits
    start();
    bits(8'hF0, 8'h0F, 5, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ocupado", {7'd0, ocupado}, 8'd0);
    check("rst_async_listo", {7'd0, listo}, 8'd0);
    check("rst_async_relacion", {6'd0, relacion}, 8'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("tras_rst_sin_listo", {7'd0, listo}, 8'd0);
    word(8'h55, 8'h54, 1'b0);
    word(8'h00, 8'hFF, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
